// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg -- shared types and constants for the 32-bit-to-16-bit SRAM
// controller: FSM state encoding, SRAM bus widths and the default address base.
package mem_sram_ctrl_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'd1024;

    // IDLE waits for a request, LO/HI move the low/high halfword, DONE hands the
    // result back to the pipeline for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// mem_sram_ctrl_if -- pipeline-side handshake between the EXE/MEM register
// (master) and the SRAM controller (slave). ready low means freeze the pipeline.
interface mem_sram_ctrl_if;

    logic        MEM_R_EN_In;
    logic        MEM_W_EN_In;
    logic [31:0] ALU_Res_In;
    logic [31:0] valRmIn;
    logic        ready;
    logic [31:0] Read_Data;

    modport master (
        output MEM_R_EN_In,
        output MEM_W_EN_In,
        output ALU_Res_In,
        output valRmIn,
        input  ready,
        input  Read_Data
    );

    modport slave (
        input  MEM_R_EN_In,
        input  MEM_W_EN_In,
        input  ALU_Res_In,
        input  valRmIn,
        output ready,
        output Read_Data
    );

endinterface

// File: rtl/mem_sram_ctrl_wait_counter.sv
// wait_counter -- 4-bit cycle counter that times each SRAM half-access.
// load clears it, enable advances it, tc flags the last cycle of a half.
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

    logic [3:0] count;

    // Clear on load so every half starts from zero, otherwise step while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == LAST_COUNT);

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl -- splits each 32-bit pipeline load/store into two 16-bit SRAM
// half-accesses (low half at the even word address, high half at the odd one),
// freezing the pipeline through ready while the access is in flight.
// Optional feature: define WRITE_BUF_EN to absorb a store into a one-entry
// write buffer so the pipeline keeps running while the SRAM write drains.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE
) (
    input  logic               clk,
    input  logic               rst,
    mem_sram_ctrl_if.slave     pipe,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    state_t             state;
    state_t             state_next;
    logic               req;
    logic [16:0]        eff_word;
    logic               wc_load;
    logic               wc_en;
    logic               wc_tc;
    logic               acc_write;
    logic [16:0]        acc_word;
    logic [31:0]        acc_wdata;
    logic [31:0]        read_data;
    logic               drive_dq;
    logic [SRAM_DW-1:0] dq_out;

    assign req      = pipe.MEM_R_EN_In | pipe.MEM_W_EN_In;
    // The subtraction wraps modulo 2^32, so addresses below the base simply
    // land high in the SRAM rather than raising any error.
    assign eff_word = 17'((pipe.ALU_Res_In - ADDR_BASE) >> 2);

    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (wc_load),
        .enable(wc_en),
        .tc    (wc_tc)
    );

`ifdef WRITE_BUF_EN
    logic        draining;
    logic [16:0] buf_word;
    logic [31:0] buf_data;
    logic        take_write;

    assign take_write = (state == IDLE) && pipe.MEM_W_EN_In;

    // Park an IDLE store in the buffer and remember that its drain is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            draining <= 1'b0;
            buf_word <= '0;
            buf_data <= '0;
        end else if (take_write) begin
            draining <= 1'b1;
            buf_word <= eff_word;
            buf_data <= pipe.valRmIn;
        end else if (state == DONE) begin
            draining <= 1'b0;
        end
    end

    // Every write goes through the buffer, so only a drain ever writes the SRAM;
    // anything arriving during the drain is held off until it completes.
    assign acc_write  = draining;
    assign acc_word   = draining ? buf_word : eff_word;
    assign acc_wdata  = buf_data;
    assign pipe.ready = ((state == IDLE) && (!req || pipe.MEM_W_EN_In)) ||
                        ((state == DONE) && !draining);
`else
    // The pipeline holds its request stable while frozen, so it is used live.
    assign acc_write  = pipe.MEM_W_EN_In;
    assign acc_word   = eff_word;
    assign acc_wdata  = pipe.valRmIn;
    assign pipe.ready = ((state == IDLE) && !req) || (state == DONE);
`endif

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and wait-counter control: each half lasts until terminal count
    always_comb begin
        state_next = state;
        wc_load    = 1'b1;
        wc_en      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = LO;
                end
            end
            LO: begin
                wc_load = wc_tc;
                wc_en   = 1'b1;
                if (wc_tc) begin
                    state_next = HI;
                end
            end
            HI: begin
                wc_load = wc_tc;
                wc_en   = 1'b1;
                if (wc_tc) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SRAM address, strobes and write data for the half currently on the bus
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        drive_dq  = 1'b0;
        dq_out    = acc_wdata[15:0];
        if ((state == LO) || (state == HI)) begin
            SRAM_ADDR = {acc_word, (state == HI)};
            if (acc_write) begin
                SRAM_WE_N = 1'b0;
                drive_dq  = 1'b1;
                dq_out    = (state == HI) ? acc_wdata[31:16] : acc_wdata[15:0];
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = drive_dq ? dq_out : 'z;

    // Capture each read half on the final wait cycle of its phase; the word is
    // then held until the next read replaces it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!acc_write && wc_tc) begin
            if (state == LO) begin
                read_data[15:0] <= SRAM_DQ;
            end else if (state == HI) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    assign pipe.Read_Data = read_data;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl -- bench for mem_sram_ctrl: two instances (WAIT_CYCLES 2 and
// 1) each with a behavioural 16-bit SRAM, plus a word-level reference memory
// that predicts load results. Honours WRITE_BUF_EN when it is defined.
module tb_mem_sram_ctrl;
    import mem_sram_ctrl_pkg::*;

    localparam int          WC_A = 2;
    localparam int          WC_B = 1;
    localparam logic [31:0] BASE = 32'd1024;

    typedef struct packed {
        logic               ready;
        logic [31:0]        rdata;
        logic [SRAM_AW-1:0] addr;
        logic               we_n;
        logic               oe_n;
        logic [SRAM_DW-1:0] dq;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    mem_sram_ctrl_if bus_a ();
    mem_sram_ctrl_if bus_b ();

    wire  [SRAM_DW-1:0] dq_a;
    wire  [SRAM_DW-1:0] dq_b;
    logic [SRAM_AW-1:0] addr_a;
    logic [SRAM_AW-1:0] addr_b;
    logic               we_a, oe_a, we_b, oe_b;

    mem_sram_ctrl #(.WAIT_CYCLES(WC_A), .ADDR_BASE(BASE)) dut_a (
        .clk(clk), .rst(rst_a), .pipe(bus_a),
        .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(WC_B), .ADDR_BASE(BASE)) dut_b (
        .clk(clk), .rst(rst_b), .pipe(bus_b),
        .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b)
    );

    // Behavioural SRAMs: drive the bus while output-enabled, store on write strobe
    logic [SRAM_DW-1:0] mem_a [0:(1 << SRAM_AW) - 1];
    logic [SRAM_DW-1:0] mem_b [0:(1 << SRAM_AW) - 1];

    assign dq_a = (!oe_a && we_a) ? mem_a[addr_a] : 16'hzzzz;
    assign dq_b = (!oe_b && we_b) ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) if (!we_a) mem_a[addr_a] <= dq_a;
    always @(posedge clk) if (!we_b) mem_b[addr_b] <= dq_b;

    // Word-level reference memory per instance and the last load result expected
    logic [31:0] ref_a [int];
    logic [31:0] ref_b [int];
    logic [31:0] last_rd [2];

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? WC_A : WC_B;
    endfunction

    // 32-bit word index within the SRAM for a byte address, wrapping below the base
    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 17'((off / 4) % 131072);
    endfunction

    function automatic logic [31:0] ref_read(input int d, input logic [16:0] w);
        int k;
        k = int'(w);
        if (d == 0) return ref_a.exists(k) ? ref_a[k] : 32'h0;
        return ref_b.exists(k) ? ref_b[k] : 32'h0;
    endfunction

    task automatic ref_write(input int d, input logic [16:0] w, input logic [31:0] v);
        if (d == 0) ref_a[int'(w)] = v;
        else ref_b[int'(w)] = v;
    endtask

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.ready = bus_a.ready; o.rdata = bus_a.Read_Data; o.addr = addr_a;
            o.we_n  = we_a;        o.oe_n  = oe_a;            o.dq   = dq_a;
        end else begin
            o.ready = bus_b.ready; o.rdata = bus_b.Read_Data; o.addr = addr_b;
            o.we_n  = we_b;        o.oe_n  = oe_b;            o.dq   = dq_b;
        end
        return o;
    endfunction

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        if (d == 0) begin
            bus_a.MEM_R_EN_In = r; bus_a.MEM_W_EN_In = w; bus_a.ALU_Res_In = a; bus_a.valRmIn = v;
        end else begin
            bus_b.MEM_R_EN_In = r; bus_b.MEM_W_EN_In = w; bus_b.ALU_Res_In = a; bus_b.valRmIn = v;
        end
    endtask

    // A write sometimes raises both enables, which must still act as a write
    task automatic start_req(input int d, input bit wr, input logic [31:0] a, input logic [31:0] v);
        logic r;
        r = wr ? 1'($urandom_range(1, 0)) : 1'b1;
        drive(d, r, wr, a, v);
    endtask

    task automatic clear_req(input int d);
        drive(d, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    // Follow one stalled access from its IDLE cycle to the cycle ready returns
    task automatic watch_access(input int d, input bit wr, input logic [31:0] a,
                                input logic [31:0] v, input string tag);
        logic [16:0]        w;
        logic               hi;
        logic [SRAM_DW-1:0] exp_half;
        obs_t               o;
        int                 stall;
        int                 strobes;
        int                 errs;
        bit                 done;
        w = word_of(a);
        stall = 0; strobes = 0; errs = 0; done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            o = sample(d);
            if (o.ready) begin
                done = 1;
            end else begin
                stall++;
                if (!o.we_n || !o.oe_n) begin
                    hi = (strobes >= wc(d));
                    if (o.addr !== {w, hi}) errs++;
                    if (wr) begin
                        exp_half = hi ? v[31:16] : v[15:0];
                        if (o.we_n !== 1'b0 || o.oe_n !== 1'b1 || o.dq !== exp_half) errs++;
                    end else if (o.oe_n !== 1'b0 || o.we_n !== 1'b1) begin
                        errs++;
                    end
                    strobes++;
                end else if (o.addr !== '0) begin
                    errs++;
                end
            end
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_stall"}, stall, 1 + 2 * wc(d));
        checkOutput({tag, "_strobes"}, strobes, 2 * wc(d));
        checkOutput({tag, "_bus"}, errs, 0);
        if (done) begin
            checkOutput({tag, "_done_idlebus"}, {o.addr, o.we_n, o.oe_n}, {18'd0, 2'b11});
            if (wr) checkOutput({tag, "_rdata_held"}, o.rdata, last_rd[d]);
            else    checkOutput({tag, "_rdata"}, o.rdata, ref_read(d, w));
        end
    endtask

`ifdef WRITE_BUF_EN
    // A buffered store keeps ready high, then drains while the pipeline idles
    task automatic buffered_write(input int d, input logic [31:0] a, input logic [31:0] v, input string tag);
        obs_t o;
        int   lows;
        int   stall;
        bit   back;
        lows = 0; stall = 0; back = 0;
        @(negedge clk);
        o = sample(d);
        checkOutput({tag, "_buf_ready"}, o.ready, 1);
        @(posedge clk); #1;
        clear_req(d);
        for (int k = 0; k < 64 && !back; k++) begin
            @(negedge clk);
            o = sample(d);
            if (!o.we_n) lows++;
            if (o.ready) back = 1;
            else stall++;
        end
        checkOutput({tag, "_drain_we"}, lows, 2 * wc(d));
        checkOutput({tag, "_drain_len"}, stall, 2 * wc(d) + 1);
        ref_write(d, word_of(a), v);
        @(posedge clk); #1;
    endtask
`endif

    task automatic applyStimulus(input int d, input bit wr, input logic [31:0] a,
                                 input logic [31:0] v, input string tag);
        start_req(d, wr, a, v);
`ifdef WRITE_BUF_EN
        if (wr) begin
            buffered_write(d, a, v, tag);
            return;
        end
`endif
        watch_access(d, wr, a, v, tag);
        if (wr) ref_write(d, word_of(a), v);
        else last_rd[d] = ref_read(d, word_of(a));
        @(posedge clk); #1;
        clear_req(d);
    endtask

    task automatic idle_check(input int d, input string tag);
        obs_t o;
        @(negedge clk);
        o = sample(d);
        checkOutput({tag, "_ready"}, o.ready, 1);
        checkOutput({tag, "_rdata"}, o.rdata, last_rd[d]);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        obs_t        o;
        logic [31:0] a;
        logic [31:0] v;
        bit          rwr;
        int          d;
        int          off;

        for (int i = 0; i < (1 << SRAM_AW); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checkOutput("rst_ready", o.ready, 1);
            checkOutput("rst_rdata", o.rdata, 0);
            checkOutput("rst_bus", {o.addr, o.we_n, o.oe_n}, {18'd0, 2'b11});
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Store 0xDEADBEEF at 1028, read it back, then confirm the result is held
        $display("[TB] directed store/load at 1028");
        applyStimulus(0, 1'b1, 32'd1028, 32'hDEADBEEF, "w1028");
        applyStimulus(0, 1'b0, 32'd1028, 32'h0, "r1028");
        idle_check(0, "r1028_hold");

        // Single-cycle halves on the second instance, back-to-back loads
        $display("[TB] WAIT_CYCLES=1 back-to-back loads");
        applyStimulus(1, 1'b1, 32'd1024, 32'h1234ABCD, "b_w1024");
        applyStimulus(1, 1'b1, 32'd1032, 32'hCAFEF00D, "b_w1032");
        applyStimulus(1, 1'b0, 32'd1024, 32'h0, "b_r1024");
        applyStimulus(1, 1'b0, 32'd1032, 32'h0, "b_r1032");

        // Address below the base wraps to the top of the SRAM
        $display("[TB] address wrap below base");
        applyStimulus(0, 1'b1, 32'd4, 32'hA5A55A5A, "wrap_w");
        applyStimulus(0, 1'b0, 32'd4, 32'h0, "wrap_r");
        applyStimulus(0, 1'b0, 32'd1028, 32'h0, "r1028_again");

        // Reset in the second HI cycle; the held request restarts from LO
        $display("[TB] reset mid-access");
`ifdef WRITE_BUF_EN
        rwr = 1'b0;
`else
        rwr = 1'b1;
`endif
        a = BASE + 32'd36;
        v = $urandom;
        start_req(0, rwr, a, v);
        repeat (4) @(posedge clk);
        #1;
        o = sample(0);
        checkOutput("pre_rst_addr", o.addr, {word_of(a), 1'b1});
        checkOutput("pre_rst_strobe", rwr ? o.we_n : o.oe_n, 0);
        rst_a = 1'b1;
        #1;
        o = sample(0);
        checkOutput("in_rst_bus", {o.addr, o.we_n, o.oe_n}, {18'd0, 2'b11});
        checkOutput("in_rst_ready", o.ready, 0);
        checkOutput("in_rst_rdata", o.rdata, 0);
        last_rd[0] = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_a = 1'b0;
        watch_access(0, rwr, a, v, "rst_restart");
        if (rwr) ref_write(0, word_of(a), v);
        else last_rd[0] = ref_read(0, word_of(a));
        @(posedge clk); #1;
        clear_req(0);

`ifdef WRITE_BUF_EN
        // Store then immediate load of the same address: load waits for the drain
        begin
            int stall;
            bit back;
            $display("[TB] buffered store followed by load");
            v = $urandom;
            start_req(0, 1'b1, 32'd1040, v);
            @(negedge clk);
            o = sample(0);
            checkOutput("rw_write_ready", o.ready, 1);
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 32'd1040, 32'h0);
            stall = 0;
            back = 0;
            for (int k = 0; k < 80 && !back; k++) begin
                @(negedge clk);
                o = sample(0);
                if (o.ready) back = 1;
                else stall++;
            end
            checkOutput("rw_stall", stall, 4 * WC_A + 2);
            checkOutput("rw_rdata", o.rdata, v);
            ref_write(0, word_of(32'd1040), v);
            last_rd[0] = v;
            @(posedge clk); #1;
            clear_req(0);
        end
`endif

        // Randomised mix of loads and stores on both instances
        $display("[TB] randomised traffic");
        for (int n = 0; n < 30; n++) begin
            d   = int'($urandom_range(1, 0));
            off = int'($urandom_range(4095, 0)) - 256;
            a   = BASE + 32'(off);
            v   = $urandom;
            applyStimulus(d, 1'($urandom_range(1, 0)), a, v, $sformatf("rnd%0d", n));
        end
        idle_check(0, "end_a");
        idle_check(1, "end_b");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: clock cycles per 16-bit SRAM half-access, legal values 1..15.
REQ-002 SHALL have parameter ADDR_BASE, default 32'd1024: byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk  in  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have ports MEM_R_EN_In, MEM_W_EN_In  in  1 each: read/write request from the EXE/MEM pipeline register.
REQ-006 SHALL have port ALU_Res_In  in  32: byte address of the access.
REQ-007 SHALL have port valRmIn  in  32: store data.
REQ-008 SHALL have port ready  out  1: low means freeze the pipeline.
REQ-009 SHALL have port Read_Data  out  32: load result.
REQ-010 SHALL have port SRAM_ADDR  out  18: SRAM word address.
REQ-011 SHALL have port SRAM_DQ  inout  16: SRAM data bus.
REQ-012 SHALL have ports SRAM_WE_N, SRAM_OE_N  out  1 each: active-low write and output enables.

Function
REQ-013 SHALL implement FSM states IDLE, LO, HI, DONE.
REQ-014 SHALL treat a request as MEM_R_EN_In|MEM_W_EN_In; if both are high, the access SHALL be a write.
REQ-015 IDLE with a request SHALL go to LO; IDLE without a request SHALL stay in IDLE.
REQ-016 LO and HI SHALL each last exactly WAIT_CYCLES cycles, counted by a 4-bit wait counter; LO SHALL then go to HI, and HI SHALL go to DONE.
REQ-017 DONE SHALL last one cycle and then go to IDLE.
REQ-018 ready SHALL be combinational: 1 in IDLE without a request and in DONE; 0 otherwise.
REQ-019 A read SHALL hold ready low for 1+2*WAIT_CYCLES cycles; with the default that is 5 cycles, and ready is high in the 6th.
REQ-020 The effective address SHALL be eff = ALU_Res_In - ADDR_BASE, mod 2^32.
REQ-021 SRAM_ADDR SHALL be {eff[18:2],1'b0} in LO, {eff[18:2],1'b1} in HI, and 0 in IDLE and DONE.
REQ-022 Reads SHALL drive SRAM_OE_N=0 in LO/HI; Read_Data[15:0] SHALL be captured on the last LO cycle and Read_Data[31:16] on the last HI cycle.
REQ-023 Read_Data SHALL be valid in DONE and held until the next read overwrites it.
REQ-024 Writes SHALL drive SRAM_WE_N=0, SRAM_OE_N=1 and SRAM_DQ=valRmIn[15:0] in LO and valRmIn[31:16] in HI.
REQ-025 Outside write LO/HI, SRAM_DQ SHALL be high-Z and SRAM_WE_N SHALL be 1.
REQ-026 Request inputs SHALL be sampled every cycle, relying on the pipeline holding them stable while ready=0.
REQ-027 Address wrap: eff below ADDR_BASE SHALL wrap per REQ-020, with no error flag.

Reset
REQ-028 While rst=1, the block SHALL be in state IDLE with wait counter 0, Read_Data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ high-Z.
REQ-029 rst asserted mid-access SHALL abort the access immediately with no further SRAM strobes; a still-pending request after release SHALL restart from LO.

Configuration
REQ-030 With WRITE_BUF_EN defined, an IDLE write SHALL latch eff and valRmIn into a one-entry buffer and keep ready=1, so the pipeline does not freeze.
REQ-031 With WRITE_BUF_EN defined, the buffered write SHALL then drain through LO/HI; its DONE SHALL not assert ready for a new request.
REQ-032 With WRITE_BUF_EN defined, any request arriving while the drain is in progress SHALL see ready=0 until the drain finishes, and SHALL then be serviced normally; this covers read-after-write ordering.
REQ-033 Without WRITE_BUF_EN, writes SHALL stall exactly as reads do (REQ-019).

Structure
REQ-034 A shared package SHALL hold the state enum, SRAM_AW=18, SRAM_DW=16 and the default ADDR_BASE.
REQ-035 The wait counter SHALL be a sub-module named wait_counter, with load, enable and terminal-count outputs.

Verification
REQ-036 Default parameters, write ALU_Res_In=1028 with valRmIn=32'hDEADBEEF -> SRAM_ADDR 2 then 3, DQ 16'hBEEF then 16'hDEAD, WE_N low for 4 cycles, ready low for 5 cycles.
REQ-037 Read of 1028 after REQ-036 (SRAM model) -> Read_Data=32'hDEADBEEF in DONE, with ready high that cycle only.
REQ-038 WAIT_CYCLES=1, back-to-back reads of 1024 and 1032 -> each freezes for 3 cycles, SRAM_ADDR 0,1 then 4,5.
REQ-039 rst pulsed in the second HI cycle of a write -> WE_N=1 and DQ=Z immediately, state IDLE; the held request restarts in LO.
REQ-040 WRITE_BUF_EN defined, write 1040 then immediate read of 1040 -> write ready stays 1, read frozen until drain done, Read_Data equals the written data.
